pwm_duty_ramp_ctrl: RTL

Soft-start duty sequencer that sits directly in front of `pwm_generator` and drives its `duty_level_i`. It accepts target duty requests over a valid/ready handshake and ramps the applied duty one level at a time. Duty changes happen only on PWM period boundaries. It runs a period counter phase-aligned with the generator's 10-cycle period and reports completion, clamping and enable-driven ramp-down.

---
 rtl/pwm_ctrl_pkg.sv | 21 ++
 rtl/pwm_duty_ramp_ctrl_if.sv | 21 ++
 rtl/pwm_period_timer.sv | 46 ++++
 rtl/pwm_duty_ramp_ctrl.sv | 113 +++++++++++
 4 files changed

// File: rtl/pwm_ctrl_pkg.sv
// Shared types and defaults for the PWM duty ramp controller and its
// pwm_generator integration.
package pwm_ctrl_pkg;

  localparam int unsigned DUTY_W       = 4;
  localparam int unsigned PWM_PERIOD   = 10;
  localparam int unsigned PWM_DUTY_MAX = 10;

  typedef enum logic {
    ST_IDLE,
    ST_RAMP
  } state_e;

  function automatic logic [DUTY_W-1:0] clamp_duty(
    input logic [DUTY_W-1:0] duty,
    input logic [DUTY_W-1:0] duty_max
  );
    return (duty > duty_max) ? duty_max : duty;
  endfunction

endpackage

// File: rtl/pwm_duty_ramp_ctrl_if.sv
// Target-duty request handshake (valid/ready) between a requester and the
// ramp controller.
interface pwm_duty_ramp_ctrl_if;
  import pwm_ctrl_pkg::*;

  logic              req_valid_i;
  logic [DUTY_W-1:0] req_duty_i;
  logic              req_ready_o;

  modport master (
    output req_valid_i,
    output req_duty_i,
    input  req_ready_o
  );

  modport slave (
    input  req_valid_i,
    input  req_duty_i,
    output req_ready_o
  );
endinterface

// File: rtl/pwm_period_timer.sv
// Free-running PWM period counter plus a step counter that strobes once every
// STEP_PERIODS period ticks while enabled.
module pwm_period_timer #(
  parameter int unsigned PERIOD       = 10,
  parameter int unsigned STEP_PERIODS = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic step_clr_i,
  input  logic step_en_i,
  output logic period_tick_o,
  output logic step_o
);

  localparam int unsigned CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int unsigned SW = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] step_q, step_d;

  assign period_tick_o = (cnt_q == CW'(PERIOD - 1));
  // Strobe is independent of clear/enable so the FSM can consume it without
  // a combinational loop; the FSM only looks at it while ramping.
  assign step_o        = period_tick_o && (step_q == SW'(STEP_PERIODS - 1));

  always_comb begin
    cnt_d  = period_tick_o ? '0 : cnt_q + CW'(1);
    step_d = step_q;
    if (step_clr_i) begin
      step_d = '0;
    end else if (step_en_i && period_tick_o) begin
      step_d = step_o ? '0 : step_q + SW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      step_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      step_q <= step_d;
    end
  end

endmodule

// File: rtl/pwm_duty_ramp_ctrl.sv
// Soft-start duty sequencer: accepts target duty requests and ramps the
// applied duty one level per STEP_PERIODS PWM periods, on period boundaries.
module pwm_duty_ramp_ctrl
  import pwm_ctrl_pkg::*;
#(
  parameter int unsigned PERIOD       = PWM_PERIOD,
  parameter int unsigned DUTY_MAX     = PWM_DUTY_MAX,
  parameter int unsigned STEP_PERIODS = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 enable_i,
  pwm_duty_ramp_ctrl_if.slave  req,
  output logic [DUTY_W-1:0]    duty_level_o,
  output logic                 period_tick_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 clamp_err_o
);

  localparam logic [DUTY_W-1:0] DMAX = DUTY_W'(DUTY_MAX);

  state_e            state_q, state_d;
  logic [DUTY_W-1:0] tgt_q, tgt_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic              done_q, done_d;
  logic              clamp_q, clamp_d;
  logic              step_clr, step_en, step;
  logic [DUTY_W-1:0] req_tgt, tgt_eff;

  pwm_period_timer #(
    .PERIOD       (PERIOD),
    .STEP_PERIODS (STEP_PERIODS)
  ) u_timer (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .step_clr_i    (step_clr),
    .step_en_i     (step_en),
    .period_tick_o (period_tick_o),
    .step_o        (step)
  );

  assign step_en         = (state_q == ST_RAMP);
  assign req_tgt         = clamp_duty(req.req_duty_i, DMAX);
  assign tgt_eff         = enable_i ? tgt_q : '0;
  // rst_ni gates ready so no request can look accepted while held in reset.
  assign req.req_ready_o = rst_ni && enable_i && (state_q == ST_IDLE);
  assign busy_o          = (state_q == ST_RAMP);
  assign duty_level_o    = duty_q;
  assign done_o          = done_q;
  assign clamp_err_o     = clamp_q;

  always_comb begin
    state_d  = state_q;
    tgt_d    = tgt_q;
    duty_d   = duty_q;
    done_d   = 1'b0;
    clamp_d  = 1'b0;
    step_clr = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!enable_i) begin
          if (duty_q != '0) begin
            tgt_d    = '0;
            state_d  = ST_RAMP;
            step_clr = 1'b1;
          end
        end else if (req.req_valid_i) begin
          tgt_d   = req_tgt;
          clamp_d = (req.req_duty_i > DMAX);
          if (req_tgt == duty_q) begin
            done_d = 1'b1;
          end else begin
            state_d  = ST_RAMP;
            step_clr = 1'b1;
          end
        end
      end
      ST_RAMP: begin
        // Disable overrides the target permanently; the step phase is kept.
        tgt_d = tgt_eff;
        if (duty_q == tgt_eff) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else if (step) begin
          duty_d = (duty_q > tgt_eff) ? duty_q - DUTY_W'(1) : duty_q + DUTY_W'(1);
          if (duty_d == tgt_eff) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      tgt_q   <= '0;
      duty_q  <= '0;
      done_q  <= 1'b0;
      clamp_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      duty_q  <= duty_d;
      done_q  <= done_d;
      clamp_q <= clamp_d;
    end
  end

endmodule
